// File: rtl/mc_ctrl_fsm_if.sv
// Control/decode bundle between the multi-cycle RV32I controller (master) and its datapath (slave).
// Carries the instruction fields and flags in, and every write-enable and mux select out.
interface mc_ctrl_fsm_if #(
    parameter int ALU_OP_W = 4
);
    logic                start;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                zf;
    logic                PC_Write;
    logic                PC0_Write;
    logic                IR_Write;
    logic                Reg_Write;
    logic                Mem_Write;
    logic                rs2_imm_s;
    logic [1:0]          w_data_s;
    logic [1:0]          PC_s;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic                retire;
    logic                illegal;
    logic [3:0]          state;

    modport master (
        input  start, opcode, funct3, funct7_5, zf,
        output PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write, rs2_imm_s,
               w_data_s, PC_s, ALU_OP, retire, illegal, state
    );

    modport slave (
        output start, opcode, funct3, funct7_5, zf,
        input  PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write, rs2_imm_s,
               w_data_s, PC_s, ALU_OP, retire, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and write-back, driving all datapath enables and selects from its state.
module mc_ctrl_fsm #(
    parameter int ALU_OP_W      = 4,
    parameter bit START_IN_IDLE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,  S_FETCH   = 4'd1,  S_DECODE  = 4'd2,  S_EXEC    = 4'd3,
        S_ALU_WB   = 4'd4,  S_MEM_ADDR = 4'd5, S_MEM_RD  = 4'd6,  S_LD_WB   = 4'd7,
        S_MEM_WR   = 4'd8,  S_LUI_WB  = 4'd9,  S_BR_CMP  = 4'd10, S_BR_DO   = 4'd11,
        S_JAL_WB   = 4'd12, S_JALR_WB = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        C_R = 4'd0, C_I = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3, C_LUI = 4'd4,
        C_BR = 4'd5, C_JAL = 4'd6, C_JALR = 4'd7, C_BAD = 4'd8
    } cls_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b1000);

    function automatic cls_t op_class(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0110111: return C_LUI;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_BAD;
        endcase
    endfunction

    // funct7_5 only selects sub/sra for R-type; for immediates it is shamt-encoding only on shifts
    function automatic logic [ALU_OP_W-1:0] alu_op_f(input cls_t c, input logic [2:0] f3, input logic f75);
        logic b3;
        case (c)
            C_R:     b3 = f75;
            C_I:     b3 = f75 & ((f3 == 3'b001) | (f3 == 3'b101));
            default: b3 = 1'b0;
        endcase
        return ALU_OP_W'({b3, f3});
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            default: return 1'b0;
        endcase
    endfunction

    state_t              state_r;
    cls_t                cls_r;
    cls_t                dec_s;
    logic [2:0]          funct3_r;
    logic [ALU_OP_W-1:0] alu_op_r;
    logic                illegal_r;

    logic                pc_write_s, pc0_write_s, ir_write_s, reg_write_s, mem_write_s;
    logic                rs2_imm_s, retire_s;
    logic [1:0]          w_data_s, pc_s;
    logic [ALU_OP_W-1:0] alu_op_s;

    assign dec_s = op_class(bus.opcode);

    // State register, decode latches and the sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= START_IN_IDLE ? S_IDLE : S_FETCH;
            cls_r     <= C_R;
            funct3_r  <= 3'b000;
            alu_op_r  <= '0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE:     state_r <= (bus.start && !illegal_r) ? S_FETCH : S_IDLE;
                S_FETCH:    state_r <= S_DECODE;
                S_DECODE: begin
                    cls_r    <= dec_s;
                    funct3_r <= bus.funct3;
                    alu_op_r <= alu_op_f(dec_s, bus.funct3, bus.funct7_5);
                    case (dec_s)
                        C_R, C_I:        state_r <= S_EXEC;
                        C_LOAD, C_STORE: state_r <= S_MEM_ADDR;
                        C_LUI:           state_r <= S_LUI_WB;
                        C_BR:            state_r <= S_BR_CMP;
                        C_JAL:           state_r <= S_JAL_WB;
                        C_JALR:          state_r <= S_JALR_WB;
                        default: begin
                            state_r   <= S_IDLE;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_EXEC:     state_r <= S_ALU_WB;
                S_MEM_ADDR: state_r <= (cls_r == C_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_r <= S_LD_WB;
                S_BR_CMP:   state_r <= S_BR_DO;
                // Instruction boundary: start is only honoured here, never mid-instruction
                S_ALU_WB, S_LD_WB, S_MEM_WR, S_LUI_WB, S_BR_DO, S_JAL_WB, S_JALR_WB:
                            state_r <= bus.start ? S_FETCH : S_IDLE;
                default:    state_r <= S_IDLE;
            endcase
        end
    end

    // Moore output decode; gated by rst_n so nothing strobes while reset is held
    always_comb begin
        pc_write_s  = 1'b0;
        pc0_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        rs2_imm_s   = 1'b0;
        retire_s    = 1'b0;
        w_data_s    = 2'b00;
        pc_s        = 2'b00;
        alu_op_s    = '0;
        if (rst_n) begin
            case (state_r)
                S_FETCH: begin
                    ir_write_s  = 1'b1;
                    pc_write_s  = 1'b1;
                    pc0_write_s = 1'b1;
                end
                S_EXEC: begin
                    alu_op_s  = alu_op_r;
                    rs2_imm_s = (cls_r == C_I);
                end
                S_ALU_WB: begin
                    reg_write_s = 1'b1;
                    retire_s    = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_op_s  = ALU_ADD;
                    rs2_imm_s = 1'b1;
                end
                S_LD_WB: begin
                    reg_write_s = 1'b1;
                    w_data_s    = 2'b10;
                    retire_s    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_s = 1'b1;
                    retire_s    = 1'b1;
                end
                S_LUI_WB: begin
                    reg_write_s = 1'b1;
                    w_data_s    = 2'b01;
                    retire_s    = 1'b1;
                end
                S_BR_CMP:   alu_op_s = ALU_SUB;
                S_BR_DO: begin
                    pc_write_s = br_taken(funct3_r, bus.zf);
                    pc_s       = 2'b01;
                    retire_s   = 1'b1;
                end
                S_JAL_WB: begin
                    reg_write_s = 1'b1;
                    w_data_s    = 2'b11;
                    pc_write_s  = 1'b1;
                    pc_s        = 2'b01;
                    retire_s    = 1'b1;
                end
                S_JALR_WB: begin
                    alu_op_s    = ALU_ADD;
                    rs2_imm_s   = 1'b1;
                    reg_write_s = 1'b1;
                    w_data_s    = 2'b11;
                    pc_write_s  = 1'b1;
                    pc_s        = 2'b10;
                    retire_s    = 1'b1;
                end
                default:    retire_s = 1'b0;
            endcase
        end else begin
            pc_write_s = 1'b0;
            ir_write_s = 1'b0;
        end
    end

    assign bus.PC_Write  = pc_write_s;
    assign bus.PC0_Write = pc0_write_s;
    assign bus.IR_Write  = ir_write_s;
    assign bus.Reg_Write = reg_write_s;
    assign bus.Mem_Write = mem_write_s;
    assign bus.rs2_imm_s = rs2_imm_s;
    assign bus.w_data_s  = w_data_s;
    assign bus.PC_s      = pc_s;
    assign bus.ALU_OP    = alu_op_s;
    assign bus.retire    = retire_s;
    assign bus.illegal   = illegal_r;
    assign bus.state     = state_r;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: each issued instruction queues its expected retire profile,
// and an independent monitor traces every instruction from FETCH and compares at retire.
module tb_mc_ctrl_fsm;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALU_OP_W(4)) bus ();
    mc_ctrl_fsm #(.ALU_OP_W(4), .START_IN_IDLE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string      nm;
        logic [3:0] last;
        int         cyc;
        logic [3:0] alu;
        logic       bimm;
        int         rw;
        int         mw;
        logic [1:0] wds;
        logic       pcw;
        logic [1:0] pcs;
    } rec_t;

    rec_t exp_q[$];

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_BR = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic rec_t mk(input string nm, input logic [3:0] last, input int cyc,
                                input logic [3:0] alu, input logic bimm, input int rw, input int mw,
                                input logic [1:0] wds, input logic pcw, input logic [1:0] pcs);
        rec_t r;
        r.nm = nm; r.last = last; r.cyc = cyc; r.alu = alu; r.bimm = bimm;
        r.rw = rw; r.mw = mw; r.wds = wds; r.pcw = pcw; r.pcs = pcs;
        return r;
    endfunction

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic z, input rec_t e);
        bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f75; bus.zf = z;
        exp_q.push_back(e);
    endtask

    task automatic wait_retire(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.retire) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no retire required=retire within 20 cycles", nm);
        end
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.state == s) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=state %0d required=state %0d", nm, bus.state, s);
        end
    endtask

    task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic z, input rec_t e);
        issue(opc, f3, f75, z, e);
        wait_retire(e.nm);
    endtask

    // Monitor: trace each instruction from FETCH, compare its profile at the retire pulse
    initial begin
        bit         in_trace = 1'b0;
        int         cyc = 0, rw = 0, mw = 0;
        logic [3:0] alu = 4'd0;
        logic       bimm = 1'b0;
        rec_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_trace = 1'b0;
            end else begin
                if (bus.state == 4'd1) begin
                    in_trace = 1'b1; cyc = 1; rw = 0; mw = 0; alu = 4'd0; bimm = 1'b0;
                end else if (in_trace) begin
                    cyc++;
                end
                if (bus.Reg_Write) rw++;
                if (bus.Mem_Write) mw++;
                if (bus.state == 4'd3 || bus.state == 4'd5 || bus.state == 4'd10 || bus.state == 4'd13) begin
                    alu  = bus.ALU_OP;
                    bimm = bus.rs2_imm_s;
                end
                if (bus.retire) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_retire actual=retire in state %0d required=no retire", bus.state);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.nm, "_last_state"}, 32'(bus.state), 32'(e.last));
                        check({e.nm, "_cycles"}, 32'(cyc), 32'(e.cyc));
                        check({e.nm, "_alu_op"}, 32'(alu), 32'(e.alu));
                        check({e.nm, "_rs2_imm_s"}, 32'(bimm), 32'(e.bimm));
                        check({e.nm, "_reg_write_cycles"}, 32'(rw), 32'(e.rw));
                        check({e.nm, "_mem_write_cycles"}, 32'(mw), 32'(e.mw));
                        check({e.nm, "_w_data_s"}, 32'(bus.w_data_s), 32'(e.wds));
                        check({e.nm, "_pc_write"}, 32'(bus.PC_Write), 32'(e.pcw));
                        check({e.nm, "_pc_s"}, 32'(bus.PC_s), 32'(e.pcs));
                    end
                    in_trace = 1'b0;
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b1; bus.opcode = OP_R; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0; bus.zf = 1'b0;
        #12;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_strobes", 32'({bus.PC_Write, bus.PC0_Write, bus.IR_Write, bus.Reg_Write,
                                  bus.Mem_Write, bus.retire, bus.illegal}), 32'd0);
        check("rst_alu_op", 32'(bus.ALU_OP), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(OP_R, 3'b000, 1'b0, 1'b0, mk("add", 4'd4, 4, 4'b0000, 1'b0, 1, 0, 2'b00, 1'b0, 2'b00));
        @(posedge clk); #1;
        check("add_back_to_fetch", 32'(bus.state), 32'd1);
        check("fetch_strobes", 32'({bus.IR_Write, bus.PC_Write, bus.PC0_Write, bus.PC_s}), 32'b11100);
        run(OP_R,    3'b000, 1'b1, 1'b0, mk("sub",   4'd4, 4, 4'b1000, 1'b0, 1, 0, 2'b00, 1'b0, 2'b00));
        run(OP_I,    3'b101, 1'b1, 1'b0, mk("srai",  4'd4, 4, 4'b1101, 1'b1, 1, 0, 2'b00, 1'b0, 2'b00));
        run(OP_I,    3'b000, 1'b1, 1'b0, mk("addi",  4'd4, 4, 4'b0000, 1'b1, 1, 0, 2'b00, 1'b0, 2'b00));
        run(OP_LD,   3'b010, 1'b0, 1'b0, mk("lw",    4'd7, 5, 4'b0000, 1'b1, 1, 0, 2'b10, 1'b0, 2'b00));
        run(OP_ST,   3'b010, 1'b0, 1'b0, mk("sw",    4'd8, 4, 4'b0000, 1'b1, 0, 1, 2'b00, 1'b0, 2'b00));
        run(OP_BR,   3'b000, 1'b0, 1'b1, mk("beq_t", 4'd11, 4, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b1, 2'b01));
        run(OP_BR,   3'b000, 1'b0, 1'b0, mk("beq_n", 4'd11, 4, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b0, 2'b01));
        run(OP_BR,   3'b001, 1'b0, 1'b1, mk("bne_n", 4'd11, 4, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b0, 2'b01));
        run(OP_BR,   3'b001, 1'b0, 1'b0, mk("bne_t", 4'd11, 4, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b1, 2'b01));
        run(OP_BR,   3'b100, 1'b0, 1'b1, mk("blt_n", 4'd11, 4, 4'b1000, 1'b0, 0, 0, 2'b00, 1'b0, 2'b01));
        run(OP_LUI,  3'b000, 1'b0, 1'b0, mk("lui",   4'd9, 3, 4'b0000, 1'b0, 1, 0, 2'b01, 1'b0, 2'b00));
        run(OP_JAL,  3'b000, 1'b0, 1'b0, mk("jal",   4'd12, 3, 4'b0000, 1'b0, 1, 0, 2'b11, 1'b1, 2'b01));
        run(OP_JALR, 3'b000, 1'b0, 1'b0, mk("jalr",  4'd13, 3, 4'b0000, 1'b1, 1, 0, 2'b11, 1'b1, 2'b10));

        // Undecodable opcode parks the FSM until reset
        bus.opcode = OP_BAD;
        for (int i = 0; i < 10 && !bus.illegal; i++) @(negedge clk);
        check("illegal_set", 32'(bus.illegal), 32'd1);
        check("illegal_state", 32'(bus.state), 32'd0);
        repeat (5) @(negedge clk);
        check("illegal_hold_state", 32'(bus.state), 32'd0);
        check("illegal_hold_ir_write", 32'(bus.IR_Write), 32'd0);
        rst_n = 1'b0;
        #1;
        check("illegal_cleared", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_R, 3'b100, 1'b0, 1'b0, mk("xor_resume", 4'd4, 4, 4'b0100, 1'b0, 1, 0, 2'b00, 1'b0, 2'b00));

        // start dropped mid-instruction: finish it, then idle
        issue(OP_R, 3'b110, 1'b0, 1'b0, mk("or_drop", 4'd4, 4, 4'b0110, 1'b0, 1, 0, 2'b00, 1'b0, 2'b00));
        wait_state(4'd3, "or_exec");
        bus.start = 1'b0;
        wait_retire("or_drop");
        @(posedge clk); #1;
        check("idle_after_drop", 32'(bus.state), 32'd0);
        repeat (2) @(posedge clk); #1;
        check("idle_hold_no_start", 32'({bus.state, bus.IR_Write}), 32'd0);

        // Reset in MEM_WR kills the write strobe immediately
        bus.opcode = OP_ST; bus.funct3 = 3'b010;
        bus.start = 1'b1;
        wait_state(4'd8, "sw_memwr");
        check("sw_memwr_on", 32'({bus.Mem_Write, bus.Reg_Write}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("sw_reset_mem_write", 32'(bus.Mem_Write), 32'd0);
        check("sw_reset_state", 32'(bus.state), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("post_reset_quiet", 32'({bus.state, bus.Mem_Write, bus.Reg_Write, bus.retire}), 32'd0);

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control unit for the RV32I core. It sequences the fetch stage (PC_Write, IR_Write) and the execute, memory and write-back datapath, one instruction at a time. It decodes the fields of the latched instruction register and steps a Moore FSM that drives every write-enable and mux select in the core.

Parameters:
ALU_OP_W, 4, width of ALU operation code
START_IN_IDLE, 1, 1 = after reset, wait in S_IDLE for start; 0 = go directly to S_FETCH

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  run enable; sampled in S_IDLE and at every instruction boundary
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
zf  in  1  ALU zero flag, registered by datapath
PC_Write  out  1  PC load enable
PC0_Write  out  1  save current PC into PC0 (return/branch base)
IR_Write  out  1  instruction register load enable
Reg_Write  out  1  register file write enable
Mem_Write  out  1  data memory write enable
rs2_imm_s  out  1  ALU B select: 0 = rs2, 1 = immediate
w_data_s  out  2  RF write data: 00 = ALU, 01 = imm (LUI), 10 = mem, 11 = PC (link)
PC_s  out  2  PC source: 00 = PC+4, 01 = PC0+imm, 10 = ALU (rs1+imm)
ALU_OP  out  4  ALU operation
retire  out  1  one-cycle pulse in the last state of each instruction
illegal  out  1  sticky; an undecodable opcode was seen
state  out  4  current state, for debug

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = S_IDLE if START_IN_IDLE = 1, else S_FETCH.
  - illegal = 0; latched ALU_OP register = 0.
  - All outputs 0 while in reset.
- Outputs are decoded from state and the latched decode registers only. The one exception is PC_Write in S_BR_DO.
- Any output not listed for a state is 0.
- State encoding: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 ALU_WB, 5 MEM_ADDR, 6 MEM_RD, 7 LD_WB, 8 MEM_WR, 9 LUI_WB, 10 BR_CMP, 11 BR_DO, 12 JAL_WB, 13 JALR_WB. Codes 14 and 15 go to IDLE.
- IDLE: start = 1 and illegal = 0 -> FETCH; otherwise stay.
- FETCH: IR_Write = 1, PC_Write = 1, PC_s = 00, PC0_Write = 1 -> DECODE.
- DECODE: latches opcode class, funct3 and ALU_OP. Next state by opcode:
  - 0110011 (R) or 0010011 (I-ALU) -> EXEC
  - 0000011 (load) or 0100011 (store) -> MEM_ADDR
  - 0110111 (LUI) -> LUI_WB
  - 1100011 (branch) -> BR_CMP
  - 1101111 (JAL) -> JAL_WB
  - 1100111 (JALR) -> JALR_WB
  - anything else -> IDLE, illegal set to 1
- ALU_OP rule: bit 3 = funct7_5 for R-type, and for I-ALU only when funct3 = 001 or 101 (shifts). Otherwise bit 3 = 0. Bits 2:0 = funct3.
  - Encoding: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- EXEC: ALU_OP = latched value; rs2_imm_s = 1 for I-ALU, 0 for R -> ALU_WB.
- ALU_WB: Reg_Write = 1, w_data_s = 00, retire -> boundary.
- MEM_ADDR: ALU_OP = 0000, rs2_imm_s = 1 -> MEM_RD for load, MEM_WR for store.
- MEM_RD -> LD_WB. LD_WB: Reg_Write = 1, w_data_s = 10, retire -> boundary.
- MEM_WR: Mem_Write = 1, retire -> boundary.
- LUI_WB: Reg_Write = 1, w_data_s = 01, retire -> boundary.
- BR_CMP: ALU_OP = 1000, rs2_imm_s = 0 -> BR_DO.
- BR_DO: PC_s = 01, retire -> boundary.
  - PC_Write = (funct3 = 000 & zf) | (funct3 = 001 & ~zf).
  - Any other funct3: not taken.
- JAL_WB: Reg_Write = 1, w_data_s = 11, PC_Write = 1, PC_s = 01, retire -> boundary.
- JALR_WB: ALU_OP = 0000, rs2_imm_s = 1, Reg_Write = 1, w_data_s = 11, PC_Write = 1, PC_s = 10, retire -> boundary.
- Boundary: the next state is FETCH if start = 1, else IDLE. Deasserting start never aborts an instruction in flight.
- Cycle counts including FETCH:
  - R/I-ALU: 4
  - load: 5
  - store: 4
  - LUI: 3
  - branch: 4
  - JAL/JALR: 3
- illegal clears only on reset. While set, the FSM stays in IDLE regardless of start.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous), with no partial write strobes after release.

Test Plan:
1. Reset with start = 1, R-type add (opcode 0110011, funct3 000, funct7_5 0) -> states 1, 2, 3, 4; ALU_OP = 0000; Reg_Write only in state 4; retire once; back to FETCH.
2. R-type sub (funct7_5 = 1) -> ALU_OP = 1000. I-type srai (0010011, funct3 101, funct7_5 = 1) -> ALU_OP = 1101, rs2_imm_s = 1. I-type addi with IR[30] = 1 -> ALU_OP = 0000.
3. Load then store -> load takes 5 cycles with w_data_s = 10 in LD_WB; store takes 4 cycles with Mem_Write high exactly 1 cycle; Reg_Write never high during the store.
4. beq with zf = 1 -> PC_Write = 1 and PC_s = 01 in BR_DO. beq with zf = 0 -> PC_Write = 0. bne inverts both results.
5. Opcode 1111111 -> DECODE -> IDLE with illegal = 1. start held at 1 -> stays in IDLE. rst_n pulse -> illegal = 0, execution resumes.
6. Drop start during EXEC -> ALU_WB completes, then IDLE. Assert rst_n = 0 during MEM_WR -> Mem_Write falls the same cycle, state = 0.
